imem_port_arbiter: RTL and testbench



---
 rtl/imem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_imem_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-ported imem between fetch and loader; 1-cycle read return tagged by owner.
// Optional IMEM_ARB_RR_EN swaps fetch-priority/starvation-guard arbitration for round-robin.
module imem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [DW-1:0] l_wdata,
  input  logic          l_halt,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          halted,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   rd_pend;
  logic   rd_owner;  // 1: outstanding read belongs to the loader
  logic   l_pri;     // loader wins a contested RUN cycle
  logic   contested;

  assign contested = f_req && l_req;

`ifdef IMEM_ARB_RR_EN
  logic last_l;

  assign l_pri = !last_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_l <= 1'b1;
    end else if (state == RUN && contested) begin
      last_l <= l_gnt;
    end
  end
`else
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;

  assign l_pri = (starve_cnt == CW'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!l_req || l_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end
`endif

  // Grants are gated by rst_n so every output is 0 while reset is held.
  always_comb begin
    f_gnt     = 1'b0;
    l_gnt     = 1'b0;
    state_nxt = state;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (f_req && !(contested && l_pri)) begin
            f_gnt = 1'b1;
          end else begin
            l_gnt = l_req;
          end
          if (l_halt) begin
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          l_gnt = l_req;
          // Fetch is never granted here, so the only fetch read that can be in
          // flight returns during this cycle; HALT follows on the next edge.
          state_nxt = HALT;
        end
        HALT: begin
          l_gnt = l_req;
          if (!l_halt) begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_pend  <= f_gnt || (l_gnt && !l_we);
      rd_owner <= l_gnt;
    end
  end

  assign halted    = (state == HALT);
  assign f_rvalid  = rd_pend && !rd_owner;
  assign l_rvalid  = rd_pend && rd_owner;
  assign f_rdata   = f_rvalid ? mem_rdata : '0;
  assign l_rdata   = l_rvalid ? mem_rdata : '0;

  assign mem_en    = f_gnt || l_gnt;
  assign mem_we    = l_gnt && l_we;
  assign mem_addr  = f_gnt ? f_addr[AW+1:2] : (l_gnt ? l_addr[AW+1:2] : '0);
  assign mem_wdata = mem_we ? l_wdata : '0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr[31:AW+2], f_addr[1:0], l_addr[31:AW+2], l_addr[1:0]};

  a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) !(f_gnt && l_gnt));
  a_no_fetch_halted: assert property (@(posedge clk) disable iff (!rst_n) (state != RUN) |-> !f_gnt);
  a_one_rvalid: assert property (@(posedge clk) disable iff (!rst_n) !(f_rvalid && l_rvalid));

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural synchronous-read RAM.
module tb_imem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f_req;
  logic [31:0]   f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          l_req;
  logic          l_we;
  logic [31:0]   l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_halt;
  logic          l_gnt;
  logic          l_rvalid;
  logic [DW-1:0] l_rdata;
  logic          halted;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_halt(l_halt),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .halted(halted),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // RAM contents during reset: word i holds 0xA0000000 + i
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < (1<<AW); i++) ram[i] <= 32'hA000_0000 + i;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic lr, input logic lw,
                       input logic [31:0] la, input logic [31:0] ld, input logic lh);
    @(negedge clk);
    f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; l_halt = lh;
    #1;
  endtask

  logic exp_l, prev_l, prev_f;

  initial begin
    rst_n = 1'b0; f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_halt = 0;
    #2;
    check("rst f_gnt", f_gnt, 0);
    check("rst l_gnt", l_gnt, 0);
    check("rst mem_en", mem_en, 0);
    check("rst halted", halted, 0);
    check("rst f_rvalid", f_rvalid, 0);
    check("rst l_rvalid", l_rvalid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // fetch only
    drive(1, 32'h0, 0, 0, 0, 0, 0);
    check("t1 f_gnt0", f_gnt, 1);
    check("t1 addr0", mem_addr, 0);
    check("t1 rvalid0", f_rvalid, 0);
    drive(1, 32'h4, 0, 0, 0, 0, 0);
    check("t1 addr1", mem_addr, 1);
    check("t1 rvalid1", f_rvalid, 1);
    check("t1 rdata1", f_rdata, 32'hA000_0000);
    check("t1 l_rvalid", l_rvalid, 0);
    drive(1, 32'h8, 0, 0, 0, 0, 0);
    check("t1 addr2", mem_addr, 2);
    check("t1 rdata2", f_rdata, 32'hA000_0001);
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    check("t1 idle en", mem_en, 0);
    check("t1 rdata3", f_rdata, 32'hA000_0002);
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    check("t1 rvalid off", f_rvalid, 0);
    check("t1 rdata off", f_rdata, 0);

    // contention: fetch 0x20 (word 8), loader read 0x40 (word 16)
    prev_l = 0; prev_f = 0;
    for (int i = 0; i < 10; i++) begin
`ifdef IMEM_ARB_RR_EN
      exp_l = (i % 2) == 1;
`else
      exp_l = (i == 4) || (i == 9);
`endif
      drive(1, 32'h20, 1, 0, 32'h40, 0, 0);
      check($sformatf("t2 l_gnt[%0d]", i), l_gnt, exp_l);
      check($sformatf("t2 f_gnt[%0d]", i), f_gnt, !exp_l);
      check($sformatf("t2 addr[%0d]", i), mem_addr, exp_l ? 16 : 8);
      check($sformatf("t2 l_rvalid[%0d]", i), l_rvalid, prev_l);
      check($sformatf("t2 f_rvalid[%0d]", i), f_rvalid, prev_f);
      if (prev_l) check($sformatf("t2 l_rdata[%0d]", i), l_rdata, 32'hA000_0010);
      if (prev_f) check($sformatf("t2 f_rdata[%0d]", i), f_rdata, 32'hA000_0008);
      prev_l = exp_l; prev_f = !exp_l;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t2 flush l_rvalid", l_rvalid, prev_l);
    check("t2 flush f_rvalid", f_rvalid, prev_f);

`ifndef IMEM_ARB_RR_EN
    // starvation grant coinciding with l_halt
    repeat (4) drive(1, 32'h20, 1, 0, 32'h40, 0, 0);
    drive(1, 32'h20, 1, 0, 32'h40, 0, 1);
    check("sh l_gnt", l_gnt, 1);
    check("sh f_gnt", f_gnt, 0);
    drive(1, 32'h20, 0, 0, 0, 0, 0);
    check("sh drain f_gnt", f_gnt, 0);
    check("sh l_rvalid", l_rvalid, 1);
    check("sh l_rdata", l_rdata, 32'hA000_0010);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("sh halted", halted, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("sh resumed", halted, 0);
`endif

    // halt while a fetch read is in flight
    drive(1, 32'hC, 0, 0, 0, 0, 1);
    check("t3 f_gnt", f_gnt, 1);
    check("t3 addr", mem_addr, 3);
    drive(1, 32'hC, 0, 0, 0, 0, 1);
    check("t3 drain f_gnt", f_gnt, 0);
    check("t3 drain rvalid", f_rvalid, 1);
    check("t3 drain rdata", f_rdata, 32'hA000_0003);
    check("t3 drain halted", halted, 0);
    drive(1, 32'hC, 1, 1, 32'h10, 32'hDEAD_BEEF, 1);
    check("t3 halted", halted, 1);
    check("t3 f ignored", f_gnt, 0);
    check("t3 l_gnt", l_gnt, 1);
    check("t3 mem_we", mem_we, 1);
    check("t3 wr addr", mem_addr, 4);
    check("t3 wdata", mem_wdata, 32'hDEAD_BEEF);
    drive(1, 32'hC, 0, 0, 0, 0, 1);
    check("t3 wr no rvalid", l_rvalid, 0);
    check("t3 no f_rvalid", f_rvalid, 0);
    drive(0, 0, 1, 0, 32'h10, 0, 1);
    check("t3 rd l_gnt", l_gnt, 1);

    // resume
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t4 l_rvalid", l_rvalid, 1);
    check("t4 l_rdata", l_rdata, 32'hDEAD_BEEF);
    check("t4 still halted", halted, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t4 halted drop", halted, 0);
    drive(1, 32'h10, 0, 0, 0, 0, 0);
    check("t4 f_gnt", f_gnt, 1);
    check("t4 addr", mem_addr, 4);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t4 rvalid", f_rvalid, 1);
    check("t4 rdata", f_rdata, 32'hDEAD_BEEF);

    // address wrap and ignored low bits
    drive(1, 32'h400, 0, 0, 0, 0, 0);
    check("t6 wrap addr", mem_addr, 0);
    drive(1, 32'h407, 0, 0, 0, 0, 0);
    check("t6 low bits", mem_addr, 1);
    check("t6 rdata0", f_rdata, 32'hA000_0000);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t6 rdata1", f_rdata, 32'hA000_0001);

    // reset the cycle after a fetch grant
    drive(1, 32'h8, 0, 0, 0, 0, 0);
    check("t5 f_gnt", f_gnt, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5 rst f_gnt", f_gnt, 0);
    check("t5 rst mem_en", mem_en, 0);
    check("t5 rst f_rvalid", f_rvalid, 0);
    check("t5 rst mem_addr", mem_addr, 0);
    @(negedge clk);
    f_req = 0;
    rst_n = 1'b1;
    #1;
    check("t5 rel f_rvalid", f_rvalid, 0);
    drive(1, 32'h8, 0, 0, 0, 0, 0);
    check("t5 run f_gnt", f_gnt, 1);
    check("t5 run f_rvalid", f_rvalid, 0);
    check("t5 run halted", halted, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("t5 rdata", f_rdata, 32'hA000_0002);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
